// File: rtl/simd_vec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : simd_vec_sequencer
// Brief    : Streams one vector operation (len operand pairs) from ram_a/ram_b
//            through a credit-controlled skid FIFO into the SIMD PE array and
//            writes each PE result back into ram_result.
// Revision : 1.0 - initial release
// ============================================================================
module simd_vec_sequencer #(
    parameter  int DATA_WIDTH      = 32,
    parameter  int PE_ELEMENTS     = 4,
    parameter  int DRAM_DEPTH      = 256,
    parameter  int FIFO_DEPTH      = 4,
    localparam int DRAM_ADDR_WIDTH = $clog2(DRAM_DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [DRAM_ADDR_WIDTH-1:0]        base_a,
    input  logic [DRAM_ADDR_WIDTH-1:0]        base_b,
    input  logic [DRAM_ADDR_WIDTH-1:0]        base_r,
    input  logic [DRAM_ADDR_WIDTH:0]          len,
    output logic                              ram_a_rd_en,
    output logic [DRAM_ADDR_WIDTH-1:0]        ram_a_read_addr,
    input  logic [PE_ELEMENTS*DATA_WIDTH-1:0] ram_a_read_data,
    output logic                              ram_b_rd_en,
    output logic [DRAM_ADDR_WIDTH-1:0]        ram_b_read_addr,
    input  logic [PE_ELEMENTS*DATA_WIDTH-1:0] ram_b_read_data,
    output logic                              pe_in_valid,
    input  logic                              pe_in_ready,
    output logic [PE_ELEMENTS*DATA_WIDTH-1:0] pe_a_data,
    output logic [PE_ELEMENTS*DATA_WIDTH-1:0] pe_b_data,
    input  logic                              pe_res_valid,
    input  logic [PE_ELEMENTS*DATA_WIDTH-1:0] pe_res_data,
    output logic                              ram_result_wr_en,
    output logic [DRAM_ADDR_WIDTH-1:0]        ram_result_write_addr,
    output logic [PE_ELEMENTS*DATA_WIDTH-1:0] ram_result_write_data,
    output logic                              busy,
    output logic                              done
);

    localparam int c_VEC_W = PE_ELEMENTS * DATA_WIDTH;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_PTR_W-1:0]           c_PTR_LAST   = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_PTR_W-1:0]           c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [c_OCC_W-1:0]           c_OCC_ONE    = c_OCC_W'(1);
    localparam logic [c_OCC_W:0]             c_FIFO_LIMIT = (c_OCC_W + 1)'(FIFO_DEPTH);
    localparam logic [DRAM_ADDR_WIDTH:0]     c_CNT_ONE    = (DRAM_ADDR_WIDTH + 1)'(1);
    localparam logic [DRAM_ADDR_WIDTH+1:0]   c_DEPTH_EXT  = (DRAM_ADDR_WIDTH + 2)'(DRAM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DRAM_ADDR_WIDTH-1:0] r_base_a;
    logic [DRAM_ADDR_WIDTH-1:0] r_base_b;
    logic [DRAM_ADDR_WIDTH-1:0] r_base_r;
    logic [DRAM_ADDR_WIDTH:0]   r_len;
    logic [DRAM_ADDR_WIDTH:0]   r_rd_cnt;
    logic [DRAM_ADDR_WIDTH:0]   r_res_cnt;
    logic                       r_inflight;

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_OCC_W-1:0] r_occ;
    logic [c_VEC_W-1:0] r_fifo_a [FIFO_DEPTH];
    logic [c_VEC_W-1:0] r_fifo_b [FIFO_DEPTH];

    logic               w_active;
    logic [c_OCC_W:0]   w_credit_used;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_fifo_valid;
    logic               w_res_accept;
    logic               w_launch;

    // Address arithmetic wraps at DRAM_DEPTH even when it is not a power of two.
    function automatic logic [DRAM_ADDR_WIDTH-1:0] wrap_add(
        input logic [DRAM_ADDR_WIDTH-1:0] base,
        input logic [DRAM_ADDR_WIDTH:0]   off
    );
        logic [DRAM_ADDR_WIDTH+1:0] sum;
        sum = {2'b00, base} + {1'b0, off};
        if (sum >= c_DEPTH_EXT) begin
            sum = sum - c_DEPTH_EXT;
        end
        return sum[DRAM_ADDR_WIDTH-1:0];
    endfunction

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + c_PTR_ONE;
    endfunction

    assign w_active      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_launch      = (r_state == S_IDLE) && start;
    assign w_fifo_valid  = (r_occ != '0);
    assign w_pop         = w_fifo_valid && pe_in_ready;
    assign w_push        = r_inflight;

    // A read issued last cycle already owns a FIFO slot, so it counts as used credit.
    assign w_credit_used = {1'b0, r_occ} + {{c_OCC_W{1'b0}}, r_inflight};
    assign w_issue       = (r_state == S_RUN) && (r_rd_cnt < r_len) &&
                           (w_credit_used < c_FIFO_LIMIT);
    assign w_res_accept  = w_active && pe_res_valid && (r_res_cnt < r_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_rd_cnt == r_len) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_res_cnt == r_len) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base_a   <= '0;
            r_base_b   <= '0;
            r_base_r   <= '0;
            r_len      <= '0;
            r_rd_cnt   <= '0;
            r_res_cnt  <= '0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_launch) begin
                r_base_a  <= base_a;
                r_base_b  <= base_b;
                r_base_r  <= base_r;
                r_len     <= len;
                r_rd_cnt  <= '0;
                r_res_cnt <= '0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_occ     <= '0;
            end else begin
                if (w_issue) begin
                    r_rd_cnt <= r_rd_cnt + c_CNT_ONE;
                end
                if (w_res_accept) begin
                    r_res_cnt <= r_res_cnt + c_CNT_ONE;
                end
                if (w_push) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                case ({w_push, w_pop})
                    2'b10:   r_occ <= r_occ + c_OCC_ONE;
                    2'b01:   r_occ <= r_occ - c_OCC_ONE;
                    default: r_occ <= r_occ;
                endcase
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_a[r_wr_ptr] <= ram_a_read_data;
            r_fifo_b[r_wr_ptr] <= ram_b_read_data;
        end
    end

    assign ram_a_rd_en           = w_issue;
    assign ram_b_rd_en           = w_issue;
    assign ram_a_read_addr       = w_issue ? wrap_add(r_base_a, r_rd_cnt) : '0;
    assign ram_b_read_addr       = w_issue ? wrap_add(r_base_b, r_rd_cnt) : '0;

    assign pe_in_valid           = w_fifo_valid;
    assign pe_a_data             = w_fifo_valid ? r_fifo_a[r_rd_ptr] : '0;
    assign pe_b_data             = w_fifo_valid ? r_fifo_b[r_rd_ptr] : '0;

    assign ram_result_wr_en      = w_res_accept;
    assign ram_result_write_addr = w_res_accept ? wrap_add(r_base_r, r_res_cnt) : '0;
    assign ram_result_write_data = w_res_accept ? pe_res_data : '0;

    assign busy                  = (r_state != S_IDLE);
    assign done                  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_simd_vec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_simd_vec_sequencer
// Brief    : Directed and randomized bench for simd_vec_sequencer with BRAM and
//            lane-wise-add PE models and a transaction-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simd_vec_sequencer;

    localparam int DW    = 32;
    localparam int PE    = 4;
    localparam int DEPTH = 256;
    localparam int FD    = 4;
    localparam int AW    = 8;
    localparam int VW    = PE * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_a, base_b, base_r;
    logic [AW:0]   len;
    logic          ram_a_rd_en, ram_b_rd_en;
    logic [AW-1:0] ram_a_read_addr, ram_b_read_addr;
    logic [VW-1:0] ram_a_read_data, ram_b_read_data;
    logic          pe_in_valid;
    logic          pe_in_ready;
    logic [VW-1:0] pe_a_data, pe_b_data;
    logic          pe_res_valid;
    logic [VW-1:0] pe_res_data;
    logic          ram_result_wr_en;
    logic [AW-1:0] ram_result_write_addr;
    logic [VW-1:0] ram_result_write_data;
    logic          busy, done;

    simd_vec_sequencer #(
        .DATA_WIDTH (DW),
        .PE_ELEMENTS(PE),
        .DRAM_DEPTH (DEPTH),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .base_a               (base_a),
        .base_b               (base_b),
        .base_r               (base_r),
        .len                  (len),
        .ram_a_rd_en          (ram_a_rd_en),
        .ram_a_read_addr      (ram_a_read_addr),
        .ram_a_read_data      (ram_a_read_data),
        .ram_b_rd_en          (ram_b_rd_en),
        .ram_b_read_addr      (ram_b_read_addr),
        .ram_b_read_data      (ram_b_read_data),
        .pe_in_valid          (pe_in_valid),
        .pe_in_ready          (pe_in_ready),
        .pe_a_data            (pe_a_data),
        .pe_b_data            (pe_b_data),
        .pe_res_valid         (pe_res_valid),
        .pe_res_data          (pe_res_data),
        .ram_result_wr_en     (ram_result_wr_en),
        .ram_result_write_addr(ram_result_write_addr),
        .ram_result_write_data(ram_result_write_data),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [VW-1:0] pe_fn(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        for (int l = 0; l < PE; l++) r[l*DW +: DW] = a[l*DW +: DW] + b[l*DW +: DW];
        return r;
    endfunction

    // BRAM and PE models: 1-cycle read latency, 2-cycle PE echo of a+b.
    logic [VW-1:0] mem_a [DEPTH];
    logic [VW-1:0] mem_b [DEPTH];
    logic          pv1 = 1'b0, pv2 = 1'b0;
    logic [VW-1:0] pd1 = '0, pd2 = '0;
    logic          inj_valid;
    logic [VW-1:0] inj_data;

    always @(posedge clk) begin
        if (ram_a_rd_en) ram_a_read_data <= mem_a[ram_a_read_addr];
        if (ram_b_rd_en) ram_b_read_data <= mem_b[ram_b_read_addr];
        pv2 <= pv1;
        pd2 <= pd1;
        pv1 <= pe_in_valid & pe_in_ready;
        pd1 <= pe_fn(pe_a_data, pe_b_data);
    end

    assign pe_res_valid = pv2 | inj_valid;
    assign pe_res_data  = inj_valid ? inj_data : pd2;

    // 0: hold low, 1: hold high, 2: random ~70% high
    int ready_mode = 1;
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       pe_in_ready = 1'b0;
            1:       pe_in_ready = 1'b1;
            default: pe_in_ready = ($urandom_range(0, 9) < 7);
        endcase
    end

    // Transaction monitor, sampled mid-cycle
    logic [AW-1:0] rd_a_q[$], rd_b_q[$], wr_addr_q[$];
    logic [VW-1:0] hs_a_q[$], hs_b_q[$], wr_data_q[$];
    int            rd_cyc_q[$], val_cyc_q[$];
    int            done_n   = 0;
    int            done_cyc = -1;
    logic          prev_stall = 1'b0;
    logic [VW-1:0] prev_a, prev_b;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (ram_a_rd_en || ram_b_rd_en) begin
                tests++;
                assert (ram_a_rd_en === ram_b_rd_en) else begin
                    fails++;
                    $error("FAIL rd_en_pair observed a=%0b b=%0b expected equal", ram_a_rd_en, ram_b_rd_en);
                end
                rd_a_q.push_back(ram_a_read_addr);
                rd_b_q.push_back(ram_b_read_addr);
                rd_cyc_q.push_back(cyc);
            end
            if (prev_stall) begin
                tests++;
                assert (pe_in_valid === 1'b1 && pe_a_data === prev_a && pe_b_data === prev_b) else begin
                    fails++;
                    $error("FAIL head_stable observed v=%0b a=%0h expected v=1 a=%0h", pe_in_valid, pe_a_data, prev_a);
                end
            end
            prev_stall = pe_in_valid && !pe_in_ready;
            prev_a     = pe_a_data;
            prev_b     = pe_b_data;
            if (pe_in_valid) val_cyc_q.push_back(cyc);
            if (pe_in_valid && pe_in_ready) begin
                hs_a_q.push_back(pe_a_data);
                hs_b_q.push_back(pe_b_data);
            end
            if (ram_result_wr_en) begin
                wr_addr_q.push_back(ram_result_write_addr);
                wr_data_q.push_back(ram_result_write_data);
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rd_a_q.delete(); rd_b_q.delete(); rd_cyc_q.delete(); val_cyc_q.delete();
        hs_a_q.delete(); hs_b_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        done_n   = 0;
        done_cyc = -1;
    endtask

    task automatic do_start(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                            input logic [AW-1:0] br, input logic [AW:0] ln, output int c0);
        @(posedge clk);
        #2;
        start  = 1'b1;
        base_a = ba;
        base_b = bb;
        base_r = br;
        len    = ln;
        c0     = cyc;
        @(posedge clk);
        #2;
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_n == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", (done_n > 0), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: pair i reads (base+i) mod DEPTH; result i lands at (base_r+i) mod DEPTH.
    task automatic check_op(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                            input logic [AW-1:0] br, input int ln);
        logic [AW-1:0] ea, eb, er;
        chk("done_count", done_n, 1);
        chk("busy_after", busy, 1'b0);
        chk("rd_count", rd_a_q.size(), ln);
        chk("pe_pairs", hs_a_q.size(), ln);
        chk("wr_count", wr_addr_q.size(), ln);
        for (int i = 0; i < ln; i++) begin
            ea = AW'((int'(ba) + i) % DEPTH);
            eb = AW'((int'(bb) + i) % DEPTH);
            er = AW'((int'(br) + i) % DEPTH);
            if (i < rd_a_q.size()) chk("rd_addr", {rd_a_q[i], rd_b_q[i]}, {ea, eb});
            if (i < hs_a_q.size()) begin
                chk("pe_a", hs_a_q[i], mem_a[ea]);
                chk("pe_b", hs_b_q[i], mem_b[eb]);
            end
            if (i < wr_addr_q.size()) begin
                chk("wr_addr", wr_addr_q[i], er);
                chk("wr_data", wr_data_q[i], pe_fn(mem_a[ea], mem_b[eb]));
            end
        end
    endtask

    initial begin
        int            c0;
        logic [AW-1:0] ra, rb, rr;
        logic [AW:0]   rl;

        for (int i = 0; i < DEPTH; i++) begin
            for (int l = 0; l < PE; l++) begin
                mem_a[i][l*DW +: DW] = $urandom;
                mem_b[i][l*DW +: DW] = $urandom;
            end
        end
        rst = 1'b1; start = 1'b0; base_a = '0; base_b = '0; base_r = '0; len = '0;
        inj_valid = 1'b0; inj_data = '0; pe_in_ready = 1'b1;
        ram_a_read_data = '0; ram_b_read_data = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_rd_en", {ram_a_rd_en, ram_b_rd_en}, 0);
        chk("rst_rd_addr", {ram_a_read_addr, ram_b_read_addr}, 0);
        chk("rst_pe_valid", pe_in_valid, 0);
        chk("rst_pe_data", pe_a_data | pe_b_data, 0);
        chk("rst_wr", {ram_result_wr_en, ram_result_write_addr}, 0);
        chk("rst_wr_data", ram_result_write_data, 0);
        chk("rst_busy_done", {busy, done}, 0);

        // Basic op with latency checks
        clear_mon();
        ready_mode = 1;
        do_start(8'h10, 8'h20, 8'h30, 9'd4, c0);
        @(negedge clk);
        chk("busy_run", busy, 1'b1);
        wait_done(100);
        check_op(8'h10, 8'h20, 8'h30, 4);
        chk("rd_cyc_n", rd_cyc_q.size(), 4);
        chk("rd_first_cyc", (rd_cyc_q.size() > 0) ? rd_cyc_q[0] : -1, c0 + 1);
        chk("rd_last_cyc", (rd_cyc_q.size() > 3) ? rd_cyc_q[3] : -1, c0 + 4);
        chk("val_cyc_n", val_cyc_q.size(), 4);
        chk("val_first_cyc", (val_cyc_q.size() > 0) ? val_cyc_q[0] : -1, c0 + 3);
        chk("val_last_cyc", (val_cyc_q.size() > 3) ? val_cyc_q[3] : -1, c0 + 6);

        // Backpressure: PE stalled for 10 cycles
        clear_mon();
        ready_mode = 0;
        do_start(8'h40, 8'h50, 8'h60, 9'd8, c0);
        repeat (10) @(posedge clk);
        chk("stall_reads", (rd_a_q.size() > 0 && rd_a_q.size() <= FD), 1);
        chk("stall_no_pairs", hs_a_q.size(), 0);
        ready_mode = 1;
        wait_done(200);
        check_op(8'h40, 8'h50, 8'h60, 8);

        // Address wrap-around
        clear_mon();
        do_start(8'hFE, 8'hFF, 8'hFD, 9'd4, c0);
        wait_done(100);
        check_op(8'hFE, 8'hFF, 8'hFD, 4);

        // Zero-length op
        clear_mon();
        do_start(8'h00, 8'h00, 8'h00, 9'd0, c0);
        wait_done(20);
        chk("len0_done_cyc", done_cyc, c0 + 1);
        check_op(8'h00, 8'h00, 8'h00, 0);

        // Spurious result in IDLE, then a second start while busy
        clear_mon();
        @(posedge clk);
        #2 inj_valid = 1'b1; inj_data = {4{32'hDEADBEEF}};
        @(posedge clk);
        #2 inj_valid = 1'b0;
        @(negedge clk);
        chk("idle_res_ignored", wr_addr_q.size(), 0);
        do_start(8'h70, 8'h90, 8'hA0, 9'd6, c0);
        @(posedge clk);
        #2 start = 1'b1; base_a = 8'h01; base_b = 8'h02; base_r = 8'h03; len = 9'd2;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done(100);
        check_op(8'h70, 8'h90, 8'hA0, 6);

        // Reset in the middle of RUN
        clear_mon();
        do_start(8'h00, 8'h80, 8'hC0, 9'd16, c0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_valid", pe_in_valid, 1'b0);
        clear_mon();
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("rst_mid_no_rd", rd_a_q.size(), 0);
        chk("rst_mid_no_wr", wr_addr_q.size(), 0);
        chk("rst_mid_no_pair", hs_a_q.size(), 0);
        chk("rst_mid_no_done", done_n, 0);

        // Randomized ops with random PE backpressure, including a full-depth one
        ready_mode = 2;
        for (int t = 0; t < 7; t++) begin
            ra = AW'($urandom_range(0, DEPTH - 1));
            rb = AW'($urandom_range(0, DEPTH - 1));
            rr = AW'($urandom_range(0, DEPTH - 1));
            rl = (t == 6) ? 9'(DEPTH) : 9'($urandom_range(1, 40));
            clear_mon();
            do_start(ra, rb, rr, rl, c0);
            wait_done(int'(rl) * 10 + 60);
            check_op(ra, rb, rr, int'(rl));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
